// File: rtl/mn_spike_window_counter_if.sv
// Slot strobe and count handshake bundle for the MN spike window counter.
interface mn_spike_window_counter_if #(
    parameter int NN = 8,
    parameter int CW = 32
);
    logic          slot_valid;
    logic [NN:0]   slot_index;
    logic          spike_in;
    logic          count_ack;
    logic [CW-1:0] count_out;
    logic          count_valid;

    modport master (
        output slot_valid, slot_index, spike_in, count_ack,
        input  count_out, count_valid
    );

    modport slave (
        input  slot_valid, slot_index, spike_in, count_ack,
        output count_out, count_valid
    );
endinterface

// File: rtl/mn_spike_window_counter.sv
// Counts MN spikes over time-multiplexed neuron slots, per frame and per
// window of win_frames frames, with a sticky-flag valid/ack count output.
module mn_spike_window_counter #(
    parameter int NN = 8,
    parameter int CW = 32
) (
    input  logic                          rawclk,
    input  logic                          reset_sim,
    input  logic                          enable,
    input  logic [15:0]                   win_frames,
    mn_spike_window_counter_if.slave      bus,
    output logic [NN+1:0]                 frame_count,
    output logic                          overrun,
    output logic                          sync_err
);
    localparam int IW = NN + 1;
    localparam int FW = NN + 2;
    localparam int SW = ((CW > FW) ? CW : FW) + 1;
    localparam logic [SW-1:0] WIN_MAX = SW'({CW{1'b1}});

    typedef enum logic [1:0] {IDLE, SYNC, COUNT} state_t;

    state_t         state, state_n;
    logic [FW-1:0]  frame_acc;
    logic [CW-1:0]  win_acc;
    logic [15:0]    frame_cnt;
    logic [15:0]    win_len;
    logic [IW-1:0]  prev_idx;

    logic           proc_slot;
    logic           discard;
    logic [IW-1:0]  idx_expect;
    logic [FW-1:0]  fa_base, fa_next;
    logic [CW-1:0]  wa_base, win_sum;
    logic [15:0]    fc_base, fc_next, win_len_eff;
    logic [SW-1:0]  sum_wide;
    logic           frame_end, win_start, win_end;

    assign idx_expect = prev_idx + IW'(1);

    always_ff @(posedge rawclk) begin
        if (reset_sim) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // A discontinuous strobe landing on slot 0 restarts the frame on the same edge.
    always_comb begin
        state_n   = state;
        proc_slot = 1'b0;
        discard   = 1'b0;
        if (!enable) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: state_n = SYNC;
                SYNC: begin
                    if (bus.slot_valid && bus.slot_index == '0) begin
                        state_n   = COUNT;
                        proc_slot = 1'b1;
                    end
                end
                COUNT: begin
                    if (bus.slot_valid) begin
                        if (bus.slot_index != idx_expect) begin
                            discard = 1'b1;
                            if (bus.slot_index == '0) begin
                                proc_slot = 1'b1;
                            end else begin
                                state_n = SYNC;
                            end
                        end else begin
                            proc_slot = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        fa_base     = discard ? '0 : frame_acc;
        wa_base     = discard ? '0 : win_acc;
        fc_base     = discard ? '0 : frame_cnt;
        fa_next     = fa_base + FW'(bus.spike_in);
        sum_wide    = SW'(wa_base) + SW'(fa_next);
        win_sum     = (sum_wide > WIN_MAX) ? '1 : sum_wide[CW-1:0];
        fc_next     = fc_base + 16'd1;
        frame_end   = proc_slot && (&bus.slot_index);
        win_start   = proc_slot && (bus.slot_index == '0) && (fc_base == '0);
        win_len_eff = win_len;
        if (win_start) begin
            win_len_eff = (win_frames == '0) ? 16'd1 : win_frames;
        end
        win_end     = frame_end && (fc_next == win_len_eff);
    end

    always_ff @(posedge rawclk) begin
        if (reset_sim) begin
            frame_acc       <= '0;
            win_acc         <= '0;
            frame_cnt       <= '0;
            win_len         <= 16'd1;
            prev_idx        <= '0;
            frame_count     <= '0;
            bus.count_out   <= '0;
            bus.count_valid <= 1'b0;
            overrun         <= 1'b0;
            sync_err        <= 1'b0;
        end else begin
            if (!enable || (discard && !proc_slot)) begin
                frame_acc <= '0;
                win_acc   <= '0;
                frame_cnt <= '0;
            end else if (proc_slot) begin
                prev_idx <= bus.slot_index;
                if (win_start) begin
                    win_len <= win_len_eff;
                end
                if (frame_end) begin
                    frame_count <= fa_next;
                    frame_acc   <= '0;
                    if (win_end) begin
                        bus.count_out <= win_sum;
                        win_acc       <= '0;
                        frame_cnt     <= '0;
                    end else begin
                        win_acc   <= win_sum;
                        frame_cnt <= fc_next;
                    end
                end else begin
                    frame_acc <= fa_next;
                    win_acc   <= wa_base;
                    frame_cnt <= fc_base;
                end
            end

            if (discard) begin
                sync_err <= 1'b1;
            end

            // A window end wins over a same-edge ack; only an unacked overwrite is an overrun.
            if (win_end) begin
                bus.count_valid <= 1'b1;
                if (bus.count_valid && !bus.count_ack) begin
                    overrun <= 1'b1;
                end
            end else if (bus.count_ack) begin
                bus.count_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mn_spike_window_counter.sv
// Table-driven, directed and randomized checks of mn_spike_window_counter (NN=1).
module tb_mn_spike_window_counter;
    logic        rawclk = 1'b0;
    logic        reset_sim;
    logic        enable;
    logic [15:0] win_frames;
    logic [2:0]  frame_count, frame_count4;
    logic        overrun, overrun4, sync_err, sync_err4;

    int n_err = 0;
    int n_chk = 0;

    mn_spike_window_counter_if #(.NN(1), .CW(32)) bus ();
    mn_spike_window_counter_if #(.NN(1), .CW(4))  bus4 ();

    mn_spike_window_counter #(.NN(1), .CW(32)) dut (
        .rawclk(rawclk), .reset_sim(reset_sim), .enable(enable), .win_frames(win_frames),
        .bus(bus.slave), .frame_count(frame_count), .overrun(overrun), .sync_err(sync_err)
    );

    mn_spike_window_counter #(.NN(1), .CW(4)) dut4 (
        .rawclk(rawclk), .reset_sim(reset_sim), .enable(enable), .win_frames(win_frames),
        .bus(bus4.slave), .frame_count(frame_count4), .overrun(overrun4), .sync_err(sync_err4)
    );

    always #5 rawclk = ~rawclk;

    // Reference model: spike bookkeeping from the counting rules, plain integers.
    bit m_on, m_cnt, m_cv, m_ovr, m_serr;
    int m_prev, m_cur, m_wsum, m_nfr, m_wlen, m_co, m_co4, m_fc, m_frames;

    task automatic model_edge();
        bit wend = 0;
        if (reset_sim) begin
            m_on = 0; m_cnt = 0; m_cv = 0; m_ovr = 0; m_serr = 0;
            m_prev = 0; m_cur = 0; m_wsum = 0; m_nfr = 0; m_wlen = 1;
            m_co = 0; m_co4 = 0; m_fc = 0;
            return;
        end
        if (!enable) begin
            m_on = 0; m_cnt = 0; m_cur = 0; m_wsum = 0; m_nfr = 0;
        end else if (!m_on) begin
            m_on = 1;
        end else if (bus.slot_valid) begin
            int idx = int'(bus.slot_index);
            if (m_cnt && idx != (m_prev + 1) % 4) begin
                m_serr = 1; m_cnt = 0; m_cur = 0; m_wsum = 0; m_nfr = 0;
            end
            if (!m_cnt && idx == 0) m_cnt = 1;
            if (m_cnt) begin
                if (idx == 0 && m_nfr == 0) m_wlen = (win_frames == 0) ? 1 : int'(win_frames);
                m_cur += int'(bus.spike_in);
                m_prev = idx;
                if (idx == 3) begin
                    m_fc = m_cur;
                    m_wsum += m_cur;
                    m_cur = 0;
                    m_nfr++;
                    m_frames++;
                    if (m_nfr == m_wlen) begin
                        m_co  = m_wsum;
                        m_co4 = (m_wsum > 15) ? 15 : m_wsum;
                        wend = 1;
                        m_wsum = 0;
                        m_nfr = 0;
                    end
                end
            end
        end
        if (wend) begin
            if (m_cv && !bus.count_ack) m_ovr = 1;
            m_cv = 1;
        end else if (bus.count_ack) begin
            m_cv = 0;
        end
    endtask

    task automatic drive(input bit r, input bit e, input bit v, input bit [1:0] i,
                         input bit s, input bit a);
        reset_sim = r;
        enable = e;
        bus.slot_valid = v;   bus4.slot_valid = v;
        bus.slot_index = i;   bus4.slot_index = i;
        bus.spike_in = s;     bus4.spike_in = s;
        bus.count_ack = a;    bus4.count_ack = a;
        @(posedge rawclk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic frame4(input bit [3:0] sp, input bit ack_last);
        for (int i = 0; i < 4; i++) drive(0, 1, 1, 2'(i), sp[i], (i == 3) ? ack_last : 1'b0);
    endtask

    typedef struct {
        bit r, e, v;
        bit [1:0] i;
        bit s, a;
        bit ecv;
        int eco, efc;
    } vec_t;

    function automatic vec_t mk(bit r, bit e, bit v, bit [1:0] i, bit s, bit a,
                                bit ecv, int eco, int efc);
        vec_t t;
        t.r = r; t.e = e; t.v = v; t.i = i; t.s = s; t.a = a;
        t.ecv = ecv; t.eco = eco; t.efc = efc;
        return t;
    endfunction

    vec_t tbl[24];

    initial begin
        int cycles;
        bit [1:0] ridx;

        // Basic 2-frame window, then an enable drop and a mid-frame re-sync at slot 2.
        tbl[0]  = mk(1,0,0,0,0,0, 0,0,0);
        tbl[1]  = mk(0,1,0,0,0,0, 0,0,0);
        tbl[2]  = mk(0,1,1,0,1,0, 0,0,0);
        tbl[3]  = mk(0,1,1,1,0,0, 0,0,0);
        tbl[4]  = mk(0,1,1,2,1,0, 0,0,0);
        tbl[5]  = mk(0,1,1,3,0,0, 0,0,2);
        tbl[6]  = mk(0,1,1,0,0,0, 0,0,2);
        tbl[7]  = mk(0,1,1,1,0,0, 0,0,2);
        tbl[8]  = mk(0,1,1,2,0,0, 0,0,2);
        tbl[9]  = mk(0,1,1,3,1,0, 1,3,1);
        tbl[10] = mk(0,1,0,0,0,1, 0,3,1);
        tbl[11] = mk(0,1,0,0,0,1, 0,3,1);
        tbl[12] = mk(0,0,0,0,0,0, 0,3,1);
        tbl[13] = mk(0,1,1,2,1,0, 0,3,1);
        tbl[14] = mk(0,1,1,3,1,0, 0,3,1);
        tbl[15] = mk(0,1,1,0,1,0, 0,3,1);
        tbl[16] = mk(0,1,1,1,0,0, 0,3,1);
        tbl[17] = mk(0,1,1,2,0,0, 0,3,1);
        tbl[18] = mk(0,1,1,3,1,0, 0,3,2);
        tbl[19] = mk(0,1,1,0,0,0, 0,3,2);
        tbl[20] = mk(0,1,1,1,1,0, 0,3,2);
        tbl[21] = mk(0,1,1,2,1,0, 0,3,2);
        tbl[22] = mk(0,1,1,3,1,0, 1,5,3);
        tbl[23] = mk(0,1,0,0,0,1, 0,5,3);

        win_frames = 16'd2;
        foreach (tbl[k]) begin
            drive(tbl[k].r, tbl[k].e, tbl[k].v, tbl[k].i, tbl[k].s, tbl[k].a);
            chk($sformatf("tbl%0d count_valid", k), 64'(bus.count_valid), 64'(tbl[k].ecv));
            chk($sformatf("tbl%0d count_out", k), 64'(bus.count_out), 64'(tbl[k].eco));
            chk($sformatf("tbl%0d frame_count", k), 64'(frame_count), 64'(tbl[k].efc));
            chk($sformatf("tbl%0d overrun", k), 64'(overrun), 64'(0));
            chk($sformatf("tbl%0d sync_err", k), 64'(sync_err), 64'(0));
        end

        // Overrun without ack, sticky across enable drop.
        win_frames = 16'd1;
        drive(1,0,0,0,0,0);
        drive(0,1,0,0,0,0);
        frame4(4'b0011, 0);
        chk("ovr first cv", 64'(bus.count_valid), 64'(1));
        chk("ovr first co", 64'(bus.count_out), 64'(2));
        chk("ovr first flag", 64'(overrun), 64'(0));
        frame4(4'b0011, 0);
        chk("ovr second co", 64'(bus.count_out), 64'(2));
        chk("ovr second cv", 64'(bus.count_valid), 64'(1));
        chk("ovr second flag", 64'(overrun), 64'(1));
        drive(0,0,0,0,0,0);
        chk("ovr sticky on disable", 64'(overrun), 64'(1));

        // Same-edge window end and ack: no overrun.
        drive(1,0,0,0,0,0);
        chk("ovr cleared by reset", 64'(overrun), 64'(0));
        drive(0,1,0,0,0,0);
        frame4(4'b0011, 0);
        frame4(4'b0101, 1);
        chk("sameedge co", 64'(bus.count_out), 64'(2));
        chk("sameedge cv", 64'(bus.count_valid), 64'(1));
        chk("sameedge ovr", 64'(overrun), 64'(0));

        // Discontinuity 0,1,3.
        drive(1,0,0,0,0,0);
        drive(0,1,0,0,0,0);
        drive(0,1,1,0,1,0);
        drive(0,1,1,1,1,0);
        drive(0,1,1,3,1,0);
        chk("disc sync_err", 64'(sync_err), 64'(1));
        chk("disc cv", 64'(bus.count_valid), 64'(0));
        frame4(4'b0001, 0);
        chk("disc next co", 64'(bus.count_out), 64'(1));
        chk("disc next cv", 64'(bus.count_valid), 64'(1));
        drive(0,0,0,0,0,1);
        chk("serr sticky on disable", 64'(sync_err), 64'(1));

        // win_frames = 0 behaves as 1.
        win_frames = 16'd0;
        drive(1,0,0,0,0,0);
        drive(0,1,0,0,0,0);
        frame4(4'b0111, 0);
        chk("wf0 cv", 64'(bus.count_valid), 64'(1));
        chk("wf0 co", 64'(bus.count_out), 64'(3));

        // 20 spikes in one window: CW=4 saturates at 15.
        win_frames = 16'd5;
        drive(1,0,0,0,0,0);
        drive(0,1,0,0,0,0);
        for (int f = 0; f < 4; f++) frame4(4'b1111, 0);
        chk("sat cv before end", 64'(bus4.count_valid), 64'(0));
        frame4(4'b1111, 0);
        chk("sat co cw4", 64'(bus4.count_out), 64'(15));
        chk("sat co cw32", 64'(bus.count_out), 64'(20));
        chk("sat cv", 64'(bus4.count_valid), 64'(1));

        // Reset mid-window with count_valid=1.
        drive(0,1,1,0,1,0);
        drive(0,1,1,1,1,0);
        drive(1,1,1,2,1,0);
        chk("rst co", 64'(bus.count_out), 64'(0));
        chk("rst co4", 64'(bus4.count_out), 64'(0));
        chk("rst cv", 64'(bus.count_valid), 64'(0));
        chk("rst fc", 64'(frame_count), 64'(0));
        chk("rst ovr", 64'(overrun), 64'(0));
        chk("rst serr", 64'(sync_err), 64'(0));
        win_frames = 16'd1;
        frame4(4'b1111, 0);
        chk("rst idle cv", 64'(bus.count_valid), 64'(0));
        chk("rst idle fc", 64'(frame_count), 64'(0));
        chk("rst idle serr", 64'(sync_err), 64'(0));

        // Randomized run against the model.
        drive(1,0,0,0,0,0);
        m_frames = 0;
        ridx = 2'd0;
        cycles = 0;
        while (m_frames < 1000 && cycles < 40000) begin
            bit r, e, v, s, a;
            bit [1:0] i;
            r = ($urandom_range(0, 1999) == 0);
            e = ($urandom_range(0, 299) != 0);
            v = ($urandom_range(0, 2) != 0);
            s = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0);
            i = ridx;
            if (v && $urandom_range(0, 199) == 0) i = 2'($urandom_range(0, 3));
            if (v) ridx = i + 2'd1;
            win_frames = 16'($urandom_range(0, 3));
            drive(r, e, v, i, s, a);
            chk("rnd count_out", 64'(bus.count_out), 64'(m_co));
            chk("rnd count_valid", 64'(bus.count_valid), 64'(m_cv));
            chk("rnd frame_count", 64'(frame_count), 64'(m_fc));
            chk("rnd overrun", 64'(overrun), 64'(m_ovr));
            chk("rnd sync_err", 64'(sync_err), 64'(m_serr));
            chk("rnd count_out cw4", 64'(bus4.count_out), 64'(m_co4));
            cycles++;
        end
        chk("rnd frame budget", 64'(m_frames >= 1000), 64'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
